// File: rtl/trng_word_ctrl.sv
// TRNG sequencer: gates the core, discards warm-up output, packs bits into
// words, runs a repetition-count health test and offers words over valid/ready.
module trng_word_ctrl #(
  parameter int WORD_W        = 32,
  parameter int WARMUP_CYCLES = 64,
  parameter int REP_LIMIT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              trng_enable,
  input  logic              trng_bit,
  input  logic              trng_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              health_fail,
  input  logic              clear_fail
);

  localparam int WCW = $clog2(WARMUP_CYCLES + 1);
  localparam int BCW = $clog2(WORD_W);
  localparam int RCW = $clog2(REP_LIMIT + 1);

  localparam logic [WCW-1:0] WLAST = WCW'(WARMUP_CYCLES - 1);
  localparam logic [BCW-1:0] BLAST = BCW'(WORD_W - 1);
  localparam logic [RCW-1:0] RLIM  = RCW'(REP_LIMIT);

  typedef enum logic [2:0] {
    IDLE, WARMUP, COLLECT, HOLD, FAIL
  } state_t;

  state_t state, state_n;

  logic [WCW-1:0]    wcnt, wcnt_n;
  logic [BCW-1:0]    bcnt, bcnt_n;
  logic [RCW-1:0]    rlen, rlen_n, rl_inc;
  logic              last, last_n;
  logic [WORD_W-1:0] sr, sr_n, data_n;

  // A run length of zero marks "no bit seen yet since entering COLLECT".
  always_comb begin
    rl_inc = RCW'(1);
    if (rlen != '0 && trng_bit == last)
      rl_inc = rlen + 1'b1;
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    bcnt_n  = bcnt;
    rlen_n  = rlen;
    last_n  = last;
    sr_n    = sr;
    data_n  = word_data;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_n = WARMUP;
          wcnt_n  = '0;
        end
      end
      WARMUP: begin
        if (!run) begin
          state_n = IDLE;
        end else if (wcnt == WLAST) begin
          state_n = COLLECT;
          bcnt_n  = '0;
          rlen_n  = '0;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      COLLECT: begin
        if (trng_valid) begin
          sr_n   = {sr[WORD_W-2:0], trng_bit};
          bcnt_n = bcnt + 1'b1;
          rlen_n = rl_inc;
          last_n = trng_bit;
          if (rl_inc == RLIM) begin
            state_n = FAIL;
            bcnt_n  = '0;
          end else if (bcnt == BLAST) begin
            state_n = HOLD;
            data_n  = sr_n;
            bcnt_n  = '0;
          end else if (!run) begin
            state_n = IDLE;
          end
        end else if (!run) begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (word_ready) begin
          if (run) begin
            state_n = COLLECT;
            bcnt_n  = '0;
            rlen_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      FAIL: begin
        if (clear_fail)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      bcnt        <= '0;
      rlen        <= '0;
      last        <= 1'b0;
      sr          <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      trng_enable <= 1'b0;
      busy        <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      state       <= state_n;
      wcnt        <= wcnt_n;
      bcnt        <= bcnt_n;
      rlen        <= rlen_n;
      last        <= last_n;
      sr          <= sr_n;
      word_data   <= data_n;
      word_valid  <= (state_n == HOLD);
      trng_enable <= (state_n == WARMUP) || (state_n == COLLECT)
                     || (state_n == HOLD);
      busy        <= (state_n == WARMUP) || (state_n == COLLECT)
                     || (state_n == HOLD);
      health_fail <= (state_n == FAIL);
    end
  end

endmodule
